// File: rtl/vga_pkg.sv
// Shared types for the VGA subsystem: video timing region, arbiter FSM state and grant owner.
package vga_pkg;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      BPORCH = 2'd1,
      ACTIVE = 2'd2,
      FPORCH = 2'd3
   } vga_state_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_VGA = 2'd1,
      GNT_CPU = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_CPU = 1'b0,
      GRANT_VGA = 1'b1
   } grant_t;

   localparam int unsigned BSEL_W = 4;

endpackage

// File: rtl/vga_sram_arbiter.sv
// Single-port SRAM arbiter between the CPU data bus and the VGA fetch engine.
// VGA is favoured during active video; a saturating wait counter bounds CPU deferral.
module vga_sram_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned CPU_MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   input  logic [1:0]        vga_state,
   output logic [DATA_W-1:0] vga_data,
   output logic              vga_done,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [BSEL_W-1:0] cpu_byte_sel,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   output logic              cpu_busy,
   output logic              sram_read,
   output logic              sram_write,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic [BSEL_W-1:0] sram_byte_sel,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              sram_busy
);

   localparam int unsigned         WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0]   MAX_WAIT = WAIT_W'(CPU_MAX_WAIT);

   arb_state_t        r_state;
   grant_t            r_last_grant;
   logic [WAIT_W-1:0] r_wait_cnt;

   logic w_vga_pend;
   logic w_cpu_pend;
   logic w_vga_active;
   logic w_grant_vga;
   logic w_grant_cpu;

   // A requester finishing this cycle is masked so a held level request is not re-granted.
   assign w_vga_pend   = vga_req & ~vga_done;
   assign w_cpu_pend   = (cpu_read | cpu_write) & ~cpu_done;
   assign w_vga_active = (vga_state == 2'(ACTIVE));
   assign cpu_busy     = (cpu_read | cpu_write) & ~cpu_done & ~rst;

   // Grant decision; only acted on in IDLE.
   always_comb begin
      w_grant_vga = 1'b0;
      w_grant_cpu = 1'b0;
      if (w_vga_pend && w_cpu_pend) begin
         if (w_vga_active && (r_wait_cnt < MAX_WAIT))
            w_grant_vga = 1'b1;
         else if (r_wait_cnt == MAX_WAIT)
            w_grant_cpu = 1'b1;
         else if (r_last_grant == GRANT_CPU)
            w_grant_vga = 1'b1;
         else
            w_grant_cpu = 1'b1;
      end else begin
         w_grant_vga = w_vga_pend;
         w_grant_cpu = w_cpu_pend;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_last_grant  <= GRANT_CPU;
         r_wait_cnt    <= '0;
         vga_data      <= '0;
         vga_done      <= 1'b0;
         cpu_rdata     <= '0;
         cpu_done      <= 1'b0;
         sram_read     <= 1'b0;
         sram_write    <= 1'b0;
         sram_addr     <= '0;
         sram_wdata    <= '0;
         sram_byte_sel <= '0;
      end else begin
         vga_done <= 1'b0;
         cpu_done <= 1'b0;

         if ((r_state == IDLE) && w_grant_cpu)
            r_wait_cnt <= '0;
         else if ((r_state != GNT_CPU) && w_cpu_pend && (r_wait_cnt < MAX_WAIT))
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

         case (r_state)
            IDLE: begin
               if (w_grant_vga) begin
                  sram_read     <= 1'b1;
                  sram_write    <= 1'b0;
                  sram_addr     <= vga_addr;
                  sram_wdata    <= '0;
                  sram_byte_sel <= '1;
                  r_state       <= GNT_VGA;
               end else if (w_grant_cpu) begin
                  // Write takes priority when the CPU raises both strobes.
                  sram_read     <= ~cpu_write;
                  sram_write    <= cpu_write;
                  sram_addr     <= cpu_addr;
                  sram_wdata    <= cpu_wdata;
                  sram_byte_sel <= cpu_byte_sel;
                  r_state       <= GNT_CPU;
               end
            end
            GNT_VGA: begin
               if (!sram_busy) begin
                  vga_data     <= sram_rdata;
                  vga_done     <= 1'b1;
                  sram_read    <= 1'b0;
                  r_last_grant <= GRANT_VGA;
                  r_state      <= IDLE;
               end
            end
            GNT_CPU: begin
               if (!sram_busy) begin
                  cpu_rdata    <= sram_rdata;
                  cpu_done     <= 1'b1;
                  sram_read    <= 1'b0;
                  sram_write   <= 1'b0;
                  r_last_grant <= GRANT_CPU;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Bench for vga_sram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbitration rules and a 16-word SRAM.
module tb_vga_sram_arbiter;

   localparam int MAXW = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        vga_req;
   logic [31:0] vga_addr;
   logic [1:0]  vga_state;
   logic [31:0] vga_data;
   logic        vga_done;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_byte_sel;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_busy;
   logic        sram_read;
   logic        sram_write;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_byte_sel;
   logic [31:0] sram_rdata;
   logic        sram_busy;

   vga_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .CPU_MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_state(vga_state),
      .vga_data(vga_data), .vga_done(vga_done),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_byte_sel(cpu_byte_sel),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
      .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_byte_sel(sram_byte_sel),
      .sram_rdata(sram_rdata), .sram_busy(sram_busy)
   );

   always #5 clk = ~clk;

   // SRAM stimulus memory (written from the DUT's strobes) and the model's own copy
   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];
   assign sram_rdata = mem[sram_addr[3:0]];

   int n_checks = 0;
   int n_errs   = 0;

   // Reference model: who owns the bus, bounded-wait counter, last winner, expected outputs
   int          m_owner;   // 0 none, 1 vga, 2 cpu
   int          m_wait;
   int          m_last;    // 1 vga, 2 cpu
   logic        e_vdone, e_cdone, e_rd, e_wr, e_cdata_ok;
   logic [31:0] e_vdata, e_cdata, e_addr, e_wdata;
   logic [3:0]  e_bsel;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int  win;
      bit  vp, cp;
      // A completing write lands in memory even if reset is sampled on the same edge
      if (m_owner == 2 && e_wr && !sram_busy)
         for (int b = 0; b < 4; b++)
            if (e_bsel[b]) ref_mem[e_addr[3:0]][8*b +: 8] = e_wdata[8*b +: 8];
      if (rst) begin
         m_owner = 0; m_wait = 0; m_last = 2;
         e_vdone = 0; e_cdone = 0; e_rd = 0; e_wr = 0; e_cdata_ok = 1;
         e_vdata = 0; e_cdata = 0; e_addr = 0; e_wdata = 0; e_bsel = 0;
         return;
      end
      vp  = vga_req && !e_vdone;
      cp  = (cpu_read || cpu_write) && !e_cdone;
      win = 0;
      if (m_owner == 0) begin
         if (vp && cp) begin
            if (vga_state == 2'd2 && m_wait < MAXW) win = 1;
            else if (m_wait == MAXW)                 win = 2;
            else                                     win = (m_last == 2) ? 1 : 2;
         end else if (vp) win = 1;
         else if (cp)     win = 2;
      end
      if (win == 2)                                   m_wait = 0;
      else if (m_owner != 2 && cp && m_wait < MAXW)  m_wait = m_wait + 1;
      e_vdone = 0;
      e_cdone = 0;
      if (m_owner != 0 && !sram_busy) begin
         if (m_owner == 1) begin
            e_vdata = ref_mem[e_addr[3:0]];
            e_vdone = 1;
         end else begin
            e_cdone    = 1;
            e_cdata_ok = !e_wr;
            if (!e_wr) e_cdata = ref_mem[e_addr[3:0]];
         end
         m_last  = m_owner;
         m_owner = 0;
         e_rd    = 0;
         e_wr    = 0;
      end else if (win == 1) begin
         m_owner = 1; e_rd = 1; e_wr = 0; e_addr = vga_addr; e_bsel = 4'hF;
      end else if (win == 2) begin
         m_owner = 2; e_wr = cpu_write; e_rd = !cpu_write;
         e_addr = cpu_addr; e_wdata = cpu_wdata; e_bsel = cpu_byte_sel;
      end
   endtask

   task automatic check_outputs();
      chk("sram_read",  32'(sram_read),  32'(e_rd));
      chk("sram_write", 32'(sram_write), 32'(e_wr));
      chk("vga_done",   32'(vga_done),   32'(e_vdone));
      chk("cpu_done",   32'(cpu_done),   32'(e_cdone));
      chk("cpu_busy",   32'(cpu_busy),   32'((cpu_read | cpu_write) & ~e_cdone & ~rst));
      chk("vga_data",   vga_data, e_vdata);
      if (e_cdata_ok) chk("cpu_rdata", cpu_rdata, e_cdata);
      if (e_rd || e_wr) begin
         chk("sram_addr", sram_addr, e_addr);
         chk("sram_bsel", 32'(sram_byte_sel), 32'(e_bsel));
      end
      if (e_wr) chk("sram_wdata", sram_wdata, e_wdata);
   endtask

   // One clock: SRAM write on the edge, model update, then check just after the edge
   task automatic tick();
      logic       wr;
      logic [3:0] wa, wb;
      logic [31:0] wd;
      wr = (sram_write === 1'b1) && !sram_busy;
      wa = sram_addr[3:0];
      wd = sram_wdata;
      wb = sram_byte_sel;
      @(posedge clk);
      model_step();
      #1;
      if (wr)
         for (int b = 0; b < 4; b++)
            if (wb[b]) mem[wa][8*b +: 8] = wd[8*b +: 8];
      check_outputs();
   endtask

   // Random masters: hold a request until its done pulse, occasionally abandon it
   task automatic drive_random(input int busy_pct, input int req_odds, input bit active_only);
      int k;
      if (e_vdone) vga_req = 0;
      else if (!vga_req && $urandom_range(0, req_odds) == 0) begin
         vga_req  = 1;
         vga_addr = 32'($urandom_range(0, 15));
      end else if (vga_req && $urandom_range(0, 59) == 0) vga_req = 0;
      if (e_cdone) begin cpu_read = 0; cpu_write = 0; end
      else if (!cpu_read && !cpu_write && $urandom_range(0, req_odds) == 0) begin
         k            = $urandom_range(0, 2);
         cpu_read     = (k != 1);
         cpu_write    = (k != 0);
         cpu_addr     = 32'($urandom_range(0, 15));
         cpu_wdata    = $urandom;
         cpu_byte_sel = 4'($urandom_range(0, 15));
      end
      sram_busy = ($urandom_range(0, 99) < busy_pct);
      if (active_only) vga_state = 2'd2;
      else if ($urandom_range(0, 7) == 0) vga_state = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
   endtask

   logic [31:0] init9;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[5] = 32'h6AAA5556;
      for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
      init9 = mem[9];

      // Reset with both requests high
      rst = 1; vga_req = 1; vga_addr = 32'd1; vga_state = 2'd0;
      cpu_read = 1; cpu_write = 0; cpu_addr = 32'd2; cpu_wdata = 0; cpu_byte_sel = 4'hF;
      sram_busy = 0;
      repeat (2) tick();
      chk("rst_strobes", {30'd0, sram_read, sram_write}, 32'd0);
      chk("rst_dones",   {29'd0, vga_done, cpu_done, cpu_busy}, 32'd0);
      chk("rst_addr",    sram_addr, 32'd0);
      vga_req = 0; cpu_read = 0;
      rst = 0;
      tick();

      // Lone VGA read of address 5
      vga_req = 1; vga_addr = 32'd5;
      tick();
      chk("vga_lone_strobe", 32'(sram_read), 32'd1);
      chk("vga_lone_addr", sram_addr, 32'd5);
      tick();
      chk("vga_lone_done", 32'(vga_done), 32'd1);
      chk("vga_lone_data", vga_data, 32'h6AAA5556);
      vga_req = 0;
      tick();

      // CPU partial write with three stall cycles
      cpu_write = 1; cpu_addr = 32'd9; cpu_wdata = 32'hDEADBEEF; cpu_byte_sel = 4'b0011;
      tick();
      chk("cpu_wr_strobe", 32'(sram_write), 32'd1);
      sram_busy = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("cpu_wr_hold", 32'(sram_write), 32'd1);
         chk("cpu_wr_addr", sram_addr, 32'd9);
         chk("cpu_wr_data", sram_wdata, 32'hDEADBEEF);
         chk("cpu_wr_busy", 32'(cpu_busy), 32'd1);
      end
      sram_busy = 0;
      tick();
      chk("cpu_wr_done", 32'(cpu_done), 32'd1);
      chk("cpu_wr_drop", 32'(sram_write), 32'd0);
      cpu_write = 0;
      tick();
      chk("cpu_wr_mem", mem[9], {init9[31:16], 16'hBEEF});

      // Reset in the middle of a stalled CPU access
      cpu_read = 1; cpu_addr = 32'd3; sram_busy = 1;
      tick();
      chk("rst_mid_strobe", 32'(sram_read), 32'd1);
      rst = 1;
      tick();
      chk("rst_mid_nostrobe", 32'(sram_read), 32'd0);
      chk("rst_mid_nodone", 32'(cpu_done), 32'd0);
      rst = 0; cpu_read = 0; sram_busy = 0;
      tick();
      chk("rst_mid_nodone2", 32'(cpu_done), 32'd0);

      // Continuous contention in sync region, then active region, then mixed traffic
      vga_state = 2'd0;
      for (int i = 0; i < 400; i++) begin
         tick();
         drive_random(0, 0, 1'b0);
         vga_state = 2'd0;
         rst = 0;
      end
      for (int i = 0; i < 800; i++) begin
         tick();
         drive_random(60, 0, 1'b1);
      end
      for (int i = 0; i < 2500; i++) begin
         tick();
         drive_random(30, 3, 1'b0);
      end
      rst = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
